aes_core_scheduler: RTL
=======================

// Module: aes_core_scheduler
// PURPOSE
//  Shares one combinational aescipher core (function_in, data, key -> cipher) between two requesters.
//  - Arbitrates between the requesters and registers the winning operands onto the core.
//  - Waits a fixed settle time, then captures the core output.
//  - Returns the result on a single valid/ready response channel tagged with the requester id.
//  Sits between the host-side request logic and the aescipher instance.
// PARAMETERS
//  SETTLE_CYC  4   cycles between operand launch and cipher capture; legal range 1..255
//  CNT_W       16  width of the completed-operation counter
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    asynchronous reset, active high
//  req0_valid   in   1    requester 0 has an operation
//  req0_ready   out  1    requester 0 operation accepted this cycle
//  req0_func    in   1    operation select, passed unmodified to core function_in
//  req0_key     in   [0:127]  cipher key
//  req0_data    in   [0:127]  input block
//  req1_*       -    -    same five signals for requester 1
//  core_func    out  1    to aescipher function_in
//  core_key     out  [0:127]  to aescipher key
//  core_data    out  [0:127]  to aescipher data
//  core_cipher  in   [0:127]  from aescipher cipher
//  rsp_valid    out  1    response available
//  rsp_ready    in   1    consumer takes response
//  rsp_id       out  1    requester that issued the response
//  rsp_data     out  [0:127]  captured core result
//  busy         out  1    state != IDLE
//  ops_cnt      out  CNT_W  completed responses, wraps to 0 at all-ones+1
// BEHAVIOUR
//  Reset values: state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0, core_* 0, ops_cnt 0, last_grant 1.
//  reqN_ready is forced to 0 while rst is high.
//  FSM states: IDLE, WAIT, RESP.
//  - IDLE: a grant captures reqN_func/key/data into core_*, loads cnt = SETTLE_CYC-1, then -> WAIT.
//  - WAIT: cnt decrements each cycle. At cnt==0: rsp_data <= core_cipher, rsp_id <= granted id,
//    rsp_valid <= 1, -> RESP.
//  - RESP: on rsp_valid & rsp_ready, ops_cnt++ and rsp_valid <= 0.
//    If a request is also granted in that same cycle -> WAIT (operands reloaded); otherwise -> IDLE.
//  Grant: combinational; reqN_ready = grant_N.
//  - Grants are possible only in IDLE, or in RESP with rsp_ready high.
//  - grant_N requires reqN_valid; at most one grant per cycle.
//  Round-robin:
//  - Only one request valid: that requester is granted.
//  - Both valid: the requester != last_grant is granted.
//  - last_grant updates on every grant.
//  Latency: accept at edge T -> rsp_valid high after edge T+SETTLE_CYC. Request operands are
//   sampled only at the accept edge.
//  Sustained throughput: one operation per SETTLE_CYC+1 cycles while rsp_ready is held high.
//  core_* hold from the accept edge until the next accept, so the core input is stable throughout WAIT.
//  rsp_valid/rsp_id/rsp_data are held stable while rsp_valid & !rsp_ready.
//  No grant while the response is stalled.
//  Reset mid-operation: the in-flight operation is discarded with no response, and all state returns
//   to the reset values.
// CONFIGURATION
//  AES_STRICT_PRIO_EN
//  - Defined: fixed priority, req0 always wins when both are valid; last_grant is not used.
//  - Undefined (default): round-robin as above.
// TESTING
//  1 rst=1 with both req valid -> req0_ready=req1_ready=0, rsp_valid=0, busy=0, ops_cnt=0.
//  2 req0 encrypt, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff
//    -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0, rsp_valid exactly 4 edges after accept.
//    Decrypt of that result -> original plaintext.
//  3 Both valid continuously, rsp_ready=1 -> grants 0,1,0,1.
//    A new accept every 5 cycles; ops_cnt increments once per response.
//  4 rsp_ready=0 for 10 cycles during RESP -> rsp_* stable, no reqN_ready.
//    rsp_ready=1 -> handshake and same-cycle grant of the pending request.
//  5 rst pulsed while in WAIT -> no rsp_valid, ops_cnt 0.
//    Next dual request after release -> req0 granted first.
//  6 AES_STRICT_PRIO_EN defined, both valid for 20 cycles -> only req0 granted, req1_ready stays 0.

Source files
------------

// File: rtl/aes_core_scheduler.sv
// Shares one combinational AES cipher core between two requesters and returns tagged responses.
// Optional build macro AES_STRICT_PRIO_EN selects fixed priority (req0 wins) instead of round-robin.
module aes_core_scheduler #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_func,
    input  logic [0:127]     req0_key,
    input  logic [0:127]     req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_func,
    input  logic [0:127]     req1_key,
    input  logic [0:127]     req1_data,
    output logic             core_func,
    output logic [0:127]     core_key,
    output logic [0:127]     core_data,
    input  logic [0:127]     core_cipher,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [0:127]     rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_cnt
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [7:0] CntLoad = 8'(SETTLE_CYC - 1);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q;
    logic               granted_id_q;
    logic               grant0, grant1, grant_any, grant_ok;
    logic               core_func_q;
    logic [0:127]       core_key_q, core_data_q;
    logic               rsp_valid_q, rsp_id_q;
    logic [0:127]       rsp_data_q;
    logic [CNT_W-1:0]   ops_cnt_q;
`ifndef AES_STRICT_PRIO_EN
    logic               last_grant_q;
`endif

    assign grant_any = grant0 | grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (grant_any) state_d = StWait;
            StWait: if (cnt_q == 8'd0) state_d = StResp;
            StResp: if (rsp_ready) state_d = grant_any ? StWait : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grant is gated by rst so nothing is accepted while the block is held in reset.
    always_comb begin
        grant_ok = !rst && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (grant_ok) begin
`ifdef AES_STRICT_PRIO_EN
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
`else
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`endif
        end
        req0_ready = grant0;
        req1_ready = grant1;
        busy       = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 8'd0;
            granted_id_q <= 1'b0;
            core_func_q  <= 1'b0;
            core_key_q   <= '0;
            core_data_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            ops_cnt_q    <= '0;
`ifndef AES_STRICT_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            if (grant_any) begin
                core_func_q  <= grant1 ? req1_func : req0_func;
                core_key_q   <= grant1 ? req1_key  : req0_key;
                core_data_q  <= grant1 ? req1_data : req0_data;
                cnt_q        <= CntLoad;
                granted_id_q <= grant1;
`ifndef AES_STRICT_PRIO_EN
                last_grant_q <= grant1;
`endif
            end
            if (state_q == StWait) begin
                if (cnt_q == 8'd0) begin
                    rsp_data_q  <= core_cipher;
                    rsp_id_q    <= granted_id_q;
                    rsp_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
            end
            if ((state_q == StResp) && rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
                ops_cnt_q   <= ops_cnt_q + CNT_W'(1);
            end
        end
    end

    assign core_func = core_func_q;
    assign core_key  = core_key_q;
    assign core_data = core_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign ops_cnt   = ops_cnt_q;

endmodule
